// File: rtl/magnitude_pkg.sv
// Shared types and helpers for the streaming magnitude / peak-window block.
package magnitude_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   localparam int unsigned MAX_HELPER_WIDTH = 64;

   // All-ones value of the given width: the saturated magnitude.
   function automatic logic [MAX_HELPER_WIDTH-1:0] sat_value(input int unsigned width);
      if (width >= MAX_HELPER_WIDTH) begin
         return '1;
      end
      return (MAX_HELPER_WIDTH'(1) << width) - MAX_HELPER_WIDTH'(1);
   endfunction

endpackage : magnitude_pkg

// File: rtl/magnitude_peak_stream_abs_sat.sv
// Two's-complement to unsigned magnitude; the most-negative input saturates
// to all ones instead of wrapping to zero.
module abs_sat
   import magnitude_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 17
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-2:0] mag_c_o,
   output logic                  sat_c_o
);

   localparam int unsigned MAG_W = DATA_WIDTH - 1;
   localparam logic [MAG_W-1:0] SAT_MAG = MAG_W'(sat_value(MAG_W));

   logic             neg;
   logic [MAG_W-1:0] low;
   logic [MAG_W-1:0] neg_val;

   assign neg     = data_i[DATA_WIDTH-1];
   assign low     = data_i[MAG_W-1:0];
   assign neg_val = (~low) + MAG_W'(1);
   assign sat_c_o = neg && (low == '0);
   assign mag_c_o = sat_c_o ? SAT_MAG : (neg ? neg_val : low);

endmodule : abs_sat

// File: rtl/magnitude_peak_stream.sv
// Registered magnitude stage behind a valid/ready handshake, plus a
// peak-magnitude tracker over fixed windows of accepted samples.
module magnitude_peak_stream
   import magnitude_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned WINDOW_LEN = 16
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-2:0] out_mag,
   output logic                  peak_valid,
   output logic [DATA_WIDTH-2:0] peak_mag,
   output logic                  sat_flag
);

   localparam int unsigned MAG_W     = DATA_WIDTH - 1;
   localparam int unsigned CNT_WIDTH = $clog2(WINDOW_LEN);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW_LEN - 1);

   logic [MAG_W-1:0]     mag;
   logic                 sat;
   logic                 accept;
   logic [MAG_W-1:0]     peak_cand;

   state_e               state_q,      state_d;
   logic                 out_valid_q,  out_valid_d;
   logic [MAG_W-1:0]     out_mag_q,    out_mag_d;
   logic                 peak_valid_q, peak_valid_d;
   logic [MAG_W-1:0]     peak_mag_q,   peak_mag_d;
   logic                 sat_q,        sat_d;
   logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;
   logic [MAG_W-1:0]     run_peak_q,   run_peak_d;

   abs_sat #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_abs_sat (
      .data_i  (in_data),
      .mag_c_o (mag),
      .sat_c_o (sat)
   );

   // Ready passes straight through from downstream so the stage never bubbles.
   assign in_ready  = !clear && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign peak_cand = (state_q == IDLE) ? mag :
                      ((run_peak_q > mag) ? run_peak_q : mag);

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_mag_d    = out_mag_q;
      peak_valid_d = 1'b0;
      peak_mag_d   = peak_mag_q;
      sat_d        = sat_q;
      cnt_d        = cnt_q;
      run_peak_d   = run_peak_q;

      if (clear) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         sat_d       = 1'b0;
         cnt_d       = '0;
         run_peak_d  = '0;
      end else begin
         if (accept) begin
            out_valid_d = 1'b1;
            out_mag_d   = mag;
            if (sat) begin
               sat_d = 1'b1;
            end
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end

         // Window closes on the accept that completes WINDOW_LEN samples.
         if (accept) begin
            if (cnt_q == CNT_LAST) begin
               peak_valid_d = 1'b1;
               peak_mag_d   = peak_cand;
               cnt_d        = '0;
               run_peak_d   = '0;
               state_d      = IDLE;
            end else begin
               cnt_d      = cnt_q + CNT_WIDTH'(1);
               run_peak_d = peak_cand;
               state_d    = ACCUM;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         out_mag_q    <= '0;
         peak_valid_q <= 1'b0;
         peak_mag_q   <= '0;
         sat_q        <= 1'b0;
         cnt_q        <= '0;
         run_peak_q   <= '0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_mag_q    <= out_mag_d;
         peak_valid_q <= peak_valid_d;
         peak_mag_q   <= peak_mag_d;
         sat_q        <= sat_d;
         cnt_q        <= cnt_d;
         run_peak_q   <= run_peak_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_mag    = out_mag_q;
   assign peak_valid = peak_valid_q;
   assign peak_mag   = peak_mag_q;
   assign sat_flag   = sat_q;

endmodule : magnitude_peak_stream

// File: doc/magnitude_peak_stream.md
Name: magnitude_peak_stream

Overview:
- Streaming, parametrised successor to the single-word magnitude block: converts two's-complement samples to unsigned magnitude with correct saturation, registered behind a valid/ready handshake.
- Also tracks the peak magnitude over fixed windows of WINDOW_LEN accepted samples and reports it as a one-cycle pulse.
- Sits between the sample datapath (filter/FFT outputs) and the level-detect/control logic.

Parameters:
- DATA_WIDTH, 17, input width including sign bit; magnitude width is DATA_WIDTH-1.
- WINDOW_LEN, 16, accepted samples per peak window; legal range 2..65535.
- CNT_WIDTH, $clog2(WINDOW_LEN), window counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: clears pipeline, window and sticky flag.
- in_valid  input  1  in_data valid.
- in_data  input  DATA_WIDTH  signed two's-complement sample.
- in_ready  output  1  block can accept a sample this cycle.
- out_valid  output  1  out_mag holds a valid magnitude.
- out_ready  input  1  downstream accepts out_mag.
- out_mag  output  DATA_WIDTH-1  registered unsigned magnitude.
- peak_valid  output  1  one-cycle pulse: peak_mag valid.
- peak_mag  output  DATA_WIDTH-1  maximum magnitude of the completed window.
- sat_flag  output  1  sticky: a most-negative input was saturated.

Behaviour:
- Reset (n_rst low, asynchronous): out_valid=0, out_mag=0, peak_valid=0, peak_mag=0, sat_flag=0, window count=0, running peak=0, FSM=IDLE.
- Magnitude function:
  - in_data[MSB]=0 → low DATA_WIDTH-1 bits unchanged.
  - Negative → two's-complement negate, truncated to DATA_WIDTH-1 bits.
  - in_data = -2^(DATA_WIDTH-1) → saturate to all ones (2^(DATA_WIDTH-1)-1) and set sat_flag. It must never wrap to 0.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready), a combinational pass-through of out_ready.
  - Accept = in_valid && in_ready. On accept, out_mag is loaded with the magnitude and out_valid=1 the next cycle (latency 1).
  - If out_valid && out_ready with no accept, out_valid drops to 0.
  - Accept and drain in the same cycle → out_valid stays 1 with the new data.
  - While out_valid && !out_ready: out_mag and out_valid hold stable and in_ready=0.
- Peak window FSM (states IDLE, ACCUM); only accepted samples count:
  - IDLE: on accept, running peak = mag, count=1, go to ACCUM. Otherwise stay.
  - ACCUM: on accept, running peak = max(running peak, mag), count+1.
  - Window end: when an accept brings count to WINDOW_LEN, the next cycle has peak_valid=1 and peak_mag = max including that sample. Count resets to 0, running peak resets to 0, and the FSM goes to IDLE.
  - A sample accepted in the cycle peak_valid is high belongs to the new window; the window end never stalls input.
  - peak_mag holds its last reported value between pulses; peak_valid is high for exactly one cycle per window.
- clear (synchronous, highest priority):
  - Next cycle: out_valid=0, count=0, running peak=0, FSM=IDLE, sat_flag=0, peak_valid=0. peak_mag is retained.
  - A sample presented with clear is not accepted.
- sat_flag is set on accept of a saturating sample (visible the next cycle) and cleared only by clear or reset. If clear and a saturating sample coincide, clear wins.
- Equal magnitudes: max keeps the value; no tie-break is needed.
- Mid-window reset or clear: the partial window is discarded with no peak_valid pulse.

Decomposition:
- Package magnitude_pkg: FSM state enum (IDLE, ACCUM) and a localparam helper for the saturated all-ones value.
- Sub-module abs_sat: combinational, parametrised by DATA_WIDTH; outputs mag and a sat indicator. Instanced once on the input side.
- Top level holds the handshake register, window counter, running-peak register and FSM.

Test Plan (DATA_WIDTH=17, WINDOW_LEN=4 unless stated):
- Basic magnitude: accept 0x00005, 0x1FFFB (-5), 0x0FFFF, 0x10001 with out_ready=1 → out_mag 5, 5, 0xFFFF, 0xFFFF, each one cycle after accept; sat_flag stays 0.
- Saturation: accept 0x10000 → out_mag=0xFFFF, sat_flag=1 the next cycle and held. Assert clear → sat_flag=0 the following cycle.
- Backpressure: out_ready=0 after the first accept → in_ready=0, out_mag/out_valid stable for 5 cycles. Raise out_ready with in_valid high → data drains and the new sample loads in the same cycle with no bubble.
- Peak window: samples 3, -9, 7, 2 back-to-back → peak_valid pulse one cycle after the 4th accept with peak_mag=9. Next samples 1,1,1,1 → peak_mag=1. Exactly one pulse per window.
- Window boundary with a gapped stream: in_valid deasserted between samples, plus a sample accepted in the peak_valid cycle → that sample counts toward the next window; 4 more accepts are needed for the next pulse.
- Reset/clear mid-window: 2 samples, then clear (or n_rst low asynchronously) → no peak_valid pulse; out_valid=0; the following 4 samples produce a peak computed only from those 4.
